wb_bus_arbiter: RTL and testbench



---
 rtl/wb_bus_pkg.sv | 19 +
 rtl/wb_bus_arbiter_rr_pick.sv | 37 +++
 rtl/wb_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// Shared types and field widths for the system-bus arbiter slice.
package wb_bus_pkg;

  localparam int ADR_W = 16;
  localparam int DAT_W = 16;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DMA = 2'd1,
    S_GAP = 2'd2
  } state_t;

  // Width of a counter/index able to hold 0..n-1, never below one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo NDMA.
module rr_pick
  import wb_bus_pkg::*;
#(
  parameter int NDMA  = 2,
  parameter int PTR_W = clog2_min1(NDMA)
) (
  input  logic [NDMA-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  localparam int SW = PTR_W + 1;

  logic [NDMA-1:0] w_rot;
  logic [SW-1:0]   w_off;
  logic [SW-1:0]   w_sum;

  // Rotate so the master at ptr sits at bit 0; the lowest set bit wins.
  assign w_rot = NDMA'({req, req} >> ptr);

  always_comb begin
    valid = 1'b0;
    w_off = '0;
    for (int i = NDMA - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        valid = 1'b1;
        w_off = SW'(i);
      end
    end
    w_sum = {1'b0, ptr} + w_off;
    if (w_sum >= SW'(NDMA)) index = PTR_W'(w_sum - SW'(NDMA));
    else                    index = w_sum[PTR_W-1:0];
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Shared Wishbone arbiter: CPU default owner, round-robin DMA tenures separated
// by a one-cycle gap, plus a bus-timeout watchdog that fakes an ack and flags an error.
module wb_bus_arbiter
  import wb_bus_pkg::*;
#(
  parameter int NDMA    = 2,
  parameter int MAXHOLD = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_p,
  input  logic                  rst_n,
  input  logic                  cpu_cyc_i,
  input  logic                  cpu_stb_i,
  input  logic                  cpu_we_i,
  input  logic [SEL_W-1:0]      cpu_sel_i,
  input  logic [ADR_W-1:0]      cpu_adr_i,
  input  logic [DAT_W-1:0]      cpu_dat_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_ack_o,
  input  logic [NDMA-1:0]       dma_req_i,
  output logic [NDMA-1:0]       dma_gnt_o,
  input  logic [NDMA-1:0]       dma_cyc_i,
  input  logic [NDMA-1:0]       dma_stb_i,
  input  logic [NDMA-1:0]       dma_we_i,
  input  logic [SEL_W*NDMA-1:0] dma_sel_i,
  input  logic [ADR_W*NDMA-1:0] dma_adr_i,
  input  logic [DAT_W*NDMA-1:0] dma_dat_i,
  output logic [NDMA-1:0]       dma_ack_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [SEL_W-1:0]      wb_sel_o,
  output logic [ADR_W-1:0]      wb_adr_o,
  output logic [DAT_W-1:0]      wb_dat_o,
  input  logic                  wb_ack_i,
  output logic                  bus_err_o,
  output state_t                dbg_state_o
);

  localparam int PTR_W  = clog2_min1(NDMA);
  localparam int HOLD_W = clog2_min1(MAXHOLD);
  localparam int WD_W   = clog2_min1(TIMEOUT + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NDMA - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAXHOLD - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT);

  state_t            r_state;
  logic [PTR_W-1:0]  r_own;
  logic [PTR_W-1:0]  r_ptr;
  logic [HOLD_W-1:0] r_hold;
  logic [WD_W-1:0]   r_wd;
  logic              r_cpu_gnt;
  logic [NDMA-1:0]   r_dma_gnt;
  logic              r_bus_err;

  logic              w_pick_valid;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_own_req;
  logic              w_ack;

  rr_pick #(.NDMA(NDMA), .PTR_W(PTR_W)) u_rr_pick (
    .req   (dma_req_i),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .index (w_pick_idx)
  );

  assign cpu_gnt_o   = r_cpu_gnt;
  assign dma_gnt_o   = r_dma_gnt;
  assign bus_err_o   = r_bus_err;
  assign dbg_state_o = r_state;
  assign w_ack       = wb_ack_i | r_bus_err;

  // Slave-side mux and ack steering, both driven only by the registered owner.
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = '0;
    wb_adr_o  = '0;
    wb_dat_o  = '0;
    cpu_ack_o = 1'b0;
    dma_ack_o = '0;
    w_own_req = 1'b0;
    case (r_state)
      S_CPU: begin
        wb_cyc_o  = cpu_cyc_i;
        wb_stb_o  = cpu_stb_i;
        wb_we_o   = cpu_we_i;
        wb_sel_o  = cpu_sel_i;
        wb_adr_o  = cpu_adr_i;
        wb_dat_o  = cpu_dat_i;
        cpu_ack_o = w_ack;
      end
      S_DMA: begin
        for (int k = 0; k < NDMA; k++) begin
          if (r_own == PTR_W'(k)) begin
            wb_cyc_o     = dma_cyc_i[k];
            wb_stb_o     = dma_stb_i[k];
            wb_we_o      = dma_we_i[k];
            wb_sel_o     = dma_sel_i[SEL_W*k +: SEL_W];
            wb_adr_o     = dma_adr_i[ADR_W*k +: ADR_W];
            wb_dat_o     = dma_dat_i[DAT_W*k +: DAT_W];
            dma_ack_o[k] = w_ack;
            w_own_req    = dma_req_i[k];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CPU;
      r_cpu_gnt <= 1'b1;
      r_dma_gnt <= '0;
      r_own     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      case (r_state)
        S_CPU: begin
          if (w_pick_valid && !cpu_cyc_i) begin
            r_state   <= S_DMA;
            r_own     <= w_pick_idx;
            r_hold    <= '0;
            r_cpu_gnt <= 1'b0;
            r_dma_gnt <= NDMA'(1) << w_pick_idx;
          end
        end
        S_DMA: begin
          // Ownership only changes between Wishbone cycles of the owner.
          if (!wb_cyc_o && (!w_own_req || r_hold == HOLD_LAST)) begin
            r_state   <= S_GAP;
            r_dma_gnt <= '0;
            r_ptr     <= (r_own == PTR_LAST) ? '0 : r_own + PTR_W'(1);
          end else if (r_hold != HOLD_LAST) begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        S_GAP: begin
          r_state   <= S_CPU;
          r_cpu_gnt <= 1'b1;
        end
        default: begin
          r_state   <= S_CPU;
          r_cpu_gnt <= 1'b1;
          r_dma_gnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      r_wd      <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      if (TIMEOUT == 0 || !wb_stb_o || wb_ack_i) begin
        r_wd <= '0;
      end else if (r_wd == WD_LAST) begin
        r_bus_err <= 1'b1;
        r_wd      <= '0;
      end else begin
        r_wd <= r_wd + WD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an ownership-level model.
module tb_wb_bus_arbiter;
  import wb_bus_pkg::*;

  localparam int NDMA    = 2;
  localparam int MAXHOLD = 64;
  localparam int TIMEOUT = 255;
  localparam int VW      = 42 + 2 * NDMA;

  logic              clk_p = 1'b0;
  logic              rst_n;
  logic              cpu_cyc_i, cpu_stb_i, cpu_we_i;
  logic [1:0]        cpu_sel_i;
  logic [15:0]       cpu_adr_i, cpu_dat_i;
  logic              cpu_gnt_o, cpu_ack_o;
  logic [NDMA-1:0]   dma_req_i, dma_gnt_o, dma_cyc_i, dma_stb_i, dma_we_i, dma_ack_o;
  logic [2*NDMA-1:0] dma_sel_i;
  logic [16*NDMA-1:0] dma_adr_i, dma_dat_i;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [1:0]        wb_sel_o;
  logic [15:0]       wb_adr_o, wb_dat_o;
  logic              wb_ack_i;
  logic              bus_err_o;
  state_t            dbg_state_o;

  int n_err = 0;
  int n_chk = 0;

  // Model: owner -1 = CPU, -2 = gap, k >= 0 = DMA master k.
  int m_owner, m_ptr, m_tenure, m_stall;
  bit m_err;

  wb_bus_arbiter #(.NDMA(NDMA), .MAXHOLD(MAXHOLD), .TIMEOUT(TIMEOUT)) dut (
    .clk_p(clk_p), .rst_n(rst_n),
    .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_ack_o(cpu_ack_o),
    .dma_req_i(dma_req_i), .dma_gnt_o(dma_gnt_o),
    .dma_cyc_i(dma_cyc_i), .dma_stb_i(dma_stb_i), .dma_we_i(dma_we_i),
    .dma_sel_i(dma_sel_i), .dma_adr_i(dma_adr_i), .dma_dat_i(dma_dat_i),
    .dma_ack_o(dma_ack_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .bus_err_o(bus_err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_p = ~clk_p;

  initial begin
    #1000000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- model ----------------
  function automatic logic [VW-1:0] model_out();
    logic cg, ca, er, cyc, stb, we, ack;
    logic [NDMA-1:0] dg, da;
    logic [1:0] sel, st;
    logic [15:0] adr, dat;
    ack = wb_ack_i | m_err;
    cg = 1'b0; ca = 1'b0; er = m_err; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    dg = '0; da = '0; sel = '0; adr = '0; dat = '0; st = S_GAP;
    if (m_owner == -1) begin
      cg = 1'b1; ca = ack; st = S_CPU;
      cyc = cpu_cyc_i; stb = cpu_stb_i; we = cpu_we_i;
      sel = cpu_sel_i; adr = cpu_adr_i; dat = cpu_dat_i;
    end else if (m_owner >= 0) begin
      dg[m_owner] = 1'b1; da[m_owner] = ack; st = S_DMA;
      cyc = dma_cyc_i[m_owner]; stb = dma_stb_i[m_owner]; we = dma_we_i[m_owner];
      sel = dma_sel_i[2*m_owner +: 2];
      adr = dma_adr_i[16*m_owner +: 16];
      dat = dma_dat_i[16*m_owner +: 16];
    end
    return {cg, dg, ca, da, er, cyc, stb, we, sel, adr, dat, st};
  endfunction

  always @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_tenure = 0; m_stall = 0; m_err = 1'b0;
    end else begin
      bit stb_now;
      bit found;
      stb_now = (m_owner == -1) ? cpu_stb_i : (m_owner >= 0) ? dma_stb_i[m_owner] : 1'b0;
      // Watchdog: an error fires after TIMEOUT+1 consecutive unanswered strobe cycles.
      m_err = 1'b0;
      if (TIMEOUT != 0 && stb_now && !wb_ack_i) begin
        m_stall++;
        if (m_stall == TIMEOUT + 1) begin
          m_err = 1'b1;
          m_stall = 0;
        end
      end else begin
        m_stall = 0;
      end
      if (m_owner == -1) begin
        if (dma_req_i != 0 && !cpu_cyc_i) begin
          found = 1'b0;
          for (int i = 0; i < NDMA; i++) begin
            if (!found && dma_req_i[(m_ptr + i) % NDMA]) begin
              m_owner = (m_ptr + i) % NDMA;
              found = 1'b1;
            end
          end
          m_tenure = 1;
        end
      end else if (m_owner >= 0) begin
        if (!dma_cyc_i[m_owner] && (!dma_req_i[m_owner] || m_tenure >= MAXHOLD)) begin
          m_ptr = (m_owner + 1) % NDMA;
          m_owner = -2;
        end else begin
          m_tenure++;
        end
      end else begin
        m_owner = -1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_p) begin
    logic [VW-1:0] e, a;
    e = model_out();
    a = {cpu_gnt_o, dma_gnt_o, cpu_ack_o, dma_ack_o, bus_err_o, wb_cyc_o, wb_stb_o,
         wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, dbg_state_o};
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL cycle_model: got 0x%0h, expected 0x%0h at %0t", a, e, $time);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_start();
    @(posedge clk_p);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_p);
  endtask

  task automatic wait_cpu(input string name);
    int c;
    c = 0;
    mid();
    while (cpu_gnt_o !== 1'b1 && c < 50) begin
      cyc_start();
      mid();
      c++;
    end
    check(name, cpu_gnt_o, 1'b1);
  endtask

  task automatic clear_inputs();
    cpu_cyc_i = 0; cpu_stb_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_adr_i = 0; cpu_dat_i = 0;
    dma_req_i = 0; dma_cyc_i = 0; dma_stb_i = 0; dma_we_i = 0;
    dma_sel_i = 0; dma_adr_i = 0; dma_dat_i = 0; wb_ack_i = 0;
  endtask

  task automatic random_cycle(input int req_flip);
    if (cpu_cyc_i) begin
      if ($urandom_range(3) == 0) cpu_cyc_i = 1'b0;
    end else if ($urandom_range(2) == 0) begin
      cpu_cyc_i = 1'b1;
    end
    cpu_stb_i = cpu_cyc_i & ($urandom_range(1) == 1);
    cpu_we_i  = ($urandom_range(1) == 1);
    cpu_sel_i = 2'($urandom_range(3));
    cpu_adr_i = 16'($urandom);
    cpu_dat_i = 16'($urandom);
    for (int k = 0; k < NDMA; k++) begin
      if ($urandom_range(req_flip) == 0) dma_req_i[k] = ~dma_req_i[k];
      if ($urandom_range(5) == 0) dma_cyc_i[k] = ~dma_cyc_i[k];
      dma_stb_i[k] = dma_cyc_i[k] & ($urandom_range(1) == 1);
    end
    dma_we_i  = NDMA'($urandom);
    dma_sel_i = (2*NDMA)'($urandom);
    dma_adr_i = (16*NDMA)'({$urandom, $urandom});
    dma_dat_i = (16*NDMA)'({$urandom, $urandom});
    wb_ack_i  = ($urandom_range(1) == 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [NDMA-1:0] owners[$];
    int ten_lens[$];
    int gap_lens[$];
    logic [NDMA-1:0] prev_dg;
    int ten_cnt, gap_cnt, t_idx, early;

    rst_n = 1'b0;
    clear_inputs();
    mid();
    check("reset_cpu_gnt", cpu_gnt_o, 1'b1);
    check("reset_dma_gnt", dma_gnt_o, 2'b00);
    check("reset_bus_err", bus_err_o, 1'b0);
    cyc_start();
    rst_n = 1'b1;

    // CPU read of the console status register.
    cyc_start();
    cpu_cyc_i = 1; cpu_stb_i = 1; cpu_sel_i = 2'b11; cpu_adr_i = 16'o177560; wb_ack_i = 1;
    mid();
    check("cpu_adr_pass", wb_adr_o, 16'o177560);
    check("cpu_ack_routed", cpu_ack_o, 1'b1);
    check("cpu_ack_not_dma", dma_ack_o, 2'b00);

    // Request while the CPU is mid-cycle for three more cycles.
    cyc_start();
    wb_ack_i = 0; dma_req_i = 2'b10;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("cpu_busy_hold", cpu_gnt_o, 1'b1);
      cyc_start();
    end
    cpu_cyc_i = 0; cpu_stb_i = 0;
    mid();
    check("grant_not_yet", dma_gnt_o, 2'b00);
    cyc_start();
    mid();
    check("grant_m1", dma_gnt_o, 2'b10);
    check("grant_cpu_off", cpu_gnt_o, 1'b0);

    cyc_start();
    dma_cyc_i = 2'b10; dma_stb_i = 2'b10; dma_we_i = 2'b10;
    dma_adr_i = 32'h1234_0000; dma_dat_i = 32'hCAFE_0000; wb_ack_i = 1;
    mid();
    check("m1_adr_pass", wb_adr_o, 16'h1234);
    check("m1_ack_only", {cpu_ack_o, dma_ack_o}, 3'b010);

    cyc_start();
    dma_cyc_i = 0; dma_stb_i = 0; dma_req_i = 0; wb_ack_i = 0;
    mid();
    check("release_n", dma_gnt_o, 2'b10);
    cyc_start();
    mid();
    check("release_gap", {cpu_gnt_o, dma_gnt_o}, 3'b000);
    cyc_start();
    mid();
    check("release_cpu", cpu_gnt_o, 1'b1);

    // Both masters hold requests with no bus cycles: alternating full-length tenures.
    cyc_start();
    dma_req_i = 2'b11;
    prev_dg = '0; ten_cnt = 0; gap_cnt = 0;
    for (int c = 0; c < 400 && owners.size() < 3; c++) begin
      mid();
      if (dma_gnt_o != 0 && prev_dg == 0) owners.push_back(dma_gnt_o);
      if (dma_gnt_o != 0) ten_cnt++;
      else if (ten_cnt > 0) begin ten_lens.push_back(ten_cnt); ten_cnt = 0; end
      if (!cpu_gnt_o && dma_gnt_o == 0) gap_cnt++;
      else if (cpu_gnt_o && gap_cnt > 0) begin gap_lens.push_back(gap_cnt); gap_cnt = 0; end
      prev_dg = dma_gnt_o;
      cyc_start();
    end
    check("rr_tenures_seen", owners.size(), 3);
    check("rr_lens_seen", ten_lens.size(), 2);
    check("rr_gaps_seen", gap_lens.size(), 2);
    if (owners.size() == 3 && ten_lens.size() == 2 && gap_lens.size() == 2) begin
      check("rr_owner0", owners[0], 2'b01);
      check("rr_owner1", owners[1], 2'b10);
      check("rr_owner2", owners[2], 2'b01);
      check("rr_tenure_len0", ten_lens[0], MAXHOLD);
      check("rr_tenure_len1", ten_lens[1], MAXHOLD);
      check("rr_gap_len0", gap_lens[0], 1);
      check("rr_gap_len1", gap_lens[1], 1);
    end
    dma_req_i = 0;
    wait_cpu("rr_return_cpu");

    // Master 0 cycles continuously for 70 cycles; release waits for its cyc=0 boundary.
    cyc_start();
    dma_req_i = 2'b01;
    for (t_idx = 1; t_idx <= 70; t_idx++) begin
      cyc_start();
      dma_req_i = 2'b11; dma_cyc_i = 2'b01; dma_stb_i = 2'b01; wb_ack_i = 1;
      mid();
      check("hold_m0", dma_gnt_o, 2'b01);
    end
    cyc_start();
    dma_cyc_i = 0; dma_stb_i = 0; wb_ack_i = 0;
    mid();
    check("boundary_cycle", dma_gnt_o, 2'b01);
    cyc_start();
    mid();
    check("forced_gap", {cpu_gnt_o, dma_gnt_o}, 3'b000);
    cyc_start();
    mid();
    check("forced_cpu_slot", cpu_gnt_o, 1'b1);
    cyc_start();
    mid();
    check("next_m1", dma_gnt_o, 2'b10);
    cyc_start();
    dma_req_i = 0;
    wait_cpu("forced_return_cpu");

    // CPU strobe that no slave answers.
    cyc_start();
    cpu_cyc_i = 1; cpu_stb_i = 1; cpu_adr_i = 16'o160000;
    early = 0; t_idx = 0;
    mid();
    while (bus_err_o !== 1'b1 && t_idx < 300) begin
      if (cpu_ack_o || dma_ack_o != 0) early++;
      cyc_start();
      mid();
      t_idx++;
    end
    check("timeout_latency", t_idx, TIMEOUT + 1);
    check("timeout_cpu_ack", cpu_ack_o, 1'b1);
    check("timeout_dma_ack", dma_ack_o, 2'b00);
    check("timeout_no_early_ack", early, 0);
    cyc_start();
    mid();
    check("timeout_one_pulse", bus_err_o, 1'b0);
    cyc_start();
    cpu_cyc_i = 0; cpu_stb_i = 0;
    wait_cpu("timeout_cpu");

    // Reset lands while master 1 is mid-cycle.
    cyc_start();
    dma_req_i = 2'b10;
    cyc_start();
    dma_cyc_i = 2'b10; dma_stb_i = 2'b10;
    mid();
    check("m1_owns_before_rst", dma_gnt_o, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_dma", dma_gnt_o, 2'b00);
    check("async_rst_cpu", cpu_gnt_o, 1'b1);
    cyc_start();
    rst_n = 1'b1;
    dma_cyc_i = 0; dma_stb_i = 0; dma_req_i = 2'b11;
    mid();
    check("post_rst_cpu", cpu_gnt_o, 1'b1);
    cyc_start();
    mid();
    check("ptr_after_reset", dma_gnt_o, 2'b01);
    cyc_start();
    dma_req_i = 0;
    wait_cpu("post_rst_return");

    // Randomized traffic; the per-cycle model comparison does the checking.
    for (int c = 0; c < 3000; c++) begin
      cyc_start();
      random_cycle(c < 1500 ? 15 : 127);
    end
    cyc_start();
    clear_inputs();
    repeat (4) cyc_start();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
